// File: rtl/psychic5_sim_pkg.sv
// psychic5_sim_pkg: pixel type, default visible window, expected pixel count and capture states
package psychic5_sim_pkg;
  typedef logic [11:0] pixel_t;
  localparam logic [8:0] DEF_H_VIS_START = 9'd0;
  localparam logic [8:0] DEF_H_VIS_END = 9'd255;
  localparam logic [8:0] DEF_V_VIS_START = 9'd16;
  localparam logic [8:0] DEF_V_VIS_END = 9'd239;
  typedef enum logic {IDLE, ACTIVE} state_t;
  function automatic logic [16:0] win_pixels(input logic [8:0] hs, he, vs, ve);
    return (17'(he - hs) + 17'd1) * (17'(ve - vs) + 17'd1);
  endfunction
  localparam logic [16:0] EXPECTED = win_pixels(DEF_H_VIS_START, DEF_H_VIS_END, DEF_V_VIS_START, DEF_V_VIS_END);
endpackage

// File: rtl/psychic5_frame_sig.sv
// psychic5_frame_sig: rotate-xor frame signature and pixel counter with load/clear/accumulate
module psychic5_frame_sig import psychic5_sim_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic        acc,
  input  pixel_t      data,
  output logic [31:0] sum_nxt,
  output logic [16:0] cnt_nxt
);
  logic [31:0] sum;
  logic [16:0] cnt;
  assign sum_nxt = {sum[30:0], sum[31]} ^ {20'd0, data};
  assign cnt_nxt = cnt + 17'd1;
  // load restarts with the current pixel and so beats clear, which beats accumulate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (load) begin
      sum <= {20'd0, data};
      cnt <= 17'd1;
    end else if (clr) begin
      sum <= '0;
      cnt <= '0;
    end else if (acc) begin
      sum <= sum_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/psychic5_screen_capture.sv
// psychic5_screen_capture: per-frame signature/count capture of Psychic 5 video in a visible window.
// SCREENSIM_DUMP_EN adds a simulation-only frame buffer dumped to frame_NNNN.ppm on each frame done.
module psychic5_screen_capture import psychic5_sim_pkg::*; #(
  parameter logic [8:0] H_VIS_START = DEF_H_VIS_START,
  parameter logic [8:0] H_VIS_END = DEF_H_VIS_END,
  parameter logic [8:0] V_VIS_START = DEF_V_VIS_START,
  parameter logic [8:0] V_VIS_END = DEF_V_VIS_END
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_MRST_n,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [8:0]  i_HCOUNTER,
  input  logic [8:0]  i_VCOUNTER,
  input  logic [11:0] i_VIDEODATA,
  output logic        o_PIX_VALID,
  output logic [8:0]  o_PIX_X,
  output logic [8:0]  o_PIX_Y,
  output logic        o_FRAME_DONE,
  output logic [15:0] o_FRAME_CNT,
  output logic [31:0] o_FRAME_SUM,
  output logic        o_FRAME_ERR
);
  localparam logic [16:0] EXP_CNT = win_pixels(H_VIS_START, H_VIS_END, V_VIS_START, V_VIS_END);
  state_t state, state_nxt;
  logic [8:0] px, py;
  logic accept, top_left, bot_right, fin, restart, abort, acc;
  logic [31:0] sum_nxt;
  logic [16:0] cnt_nxt;
  // window-relative offsets double as the range test, so a zero start needs no >= compare
  assign px = i_HCOUNTER - H_VIS_START;
  assign py = i_VCOUNTER - V_VIS_START;
  assign accept = !i_EMU_CLK6MPCEN_n && px <= H_VIS_END - H_VIS_START && py <= V_VIS_END - V_VIS_START;
  always_comb begin
    top_left = accept && px == 9'd0 && py == 9'd0;
    bot_right = accept && i_HCOUNTER == H_VIS_END && i_VCOUNTER == V_VIS_END;
    fin = bot_right && (state == ACTIVE || top_left);
    restart = top_left && !fin;
    abort = restart && state == ACTIVE;
    acc = accept && state == ACTIVE;
    state_nxt = fin ? IDLE : restart ? ACTIVE : state;
  end
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n)
    if (!i_EMU_MRST_n) begin
      state <= IDLE;
      o_PIX_VALID <= 1'b0;
      o_PIX_X <= '0;
      o_PIX_Y <= '0;
      o_FRAME_DONE <= 1'b0;
      o_FRAME_CNT <= '0;
      o_FRAME_SUM <= '0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      state <= state_nxt;
      o_PIX_VALID <= accept;
      o_FRAME_DONE <= fin;
      if (accept) begin
        o_PIX_X <= px;
        o_PIX_Y <= py;
      end
      if (fin) begin
        o_FRAME_CNT <= o_FRAME_CNT + 16'd1;
        o_FRAME_SUM <= sum_nxt;
        o_FRAME_ERR <= cnt_nxt != EXP_CNT;
      end else if (abort)
        o_FRAME_ERR <= 1'b1;
    end
  psychic5_frame_sig u_sig (
    .clk(i_EMU_MCLK),
    .rst_n(i_EMU_MRST_n),
    .clr(fin),
    .load(restart),
    .acc(acc),
    .data(i_VIDEODATA),
    .sum_nxt(sum_nxt),
    .cnt_nxt(cnt_nxt)
  );
`ifdef SCREENSIM_DUMP_EN
  pixel_t fb [0:256*224-1];
  always @(posedge i_EMU_MCLK) begin
    if (accept && !px[8] && py < 9'd224)
      fb[{py[7:0], px[7:0]}] <= i_VIDEODATA;
    if (o_FRAME_DONE) begin
      $display("frame_%04d.ppm", o_FRAME_CNT);
      $display("P3\n256 224\n255");
      for (int i = 0; i < 256*224; i++)
        $display("%0d %0d %0d", fb[i][11:8]*17, fb[i][7:4]*17, fb[i][3:0]*17);
    end
  end
`else
  // synthesizable build: no frame buffer
`endif
endmodule

// File: tb/tb_psychic5_screen_capture.sv
// tb_psychic5_screen_capture: directed checks of capture, signature, abort and reset on an 8x3 window
module tb_psychic5_screen_capture;
  logic clk = 1'b0, rst_n = 1'b0, en_n = 1'b1;
  logic [8:0] h = '0, v = '0;
  logic [11:0] d = '0;
  logic pix_valid, frame_done, frame_err;
  logic [8:0] pix_x, pix_y;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sum;
  int n_cmp = 0, n_bad = 0, dones = 0;
  logic [8:0] nh [5] = '{9'd300, 9'd10, 9'd1, 9'd2, 9'd2};
  logic [8:0] nv [5] = '{9'd5, 9'd16, 9'd17, 9'd19, 9'd15};
  always #5 clk = ~clk;
  psychic5_screen_capture #(
    .H_VIS_START(9'd2), .H_VIS_END(9'd9), .V_VIS_START(9'd16), .V_VIS_END(9'd18)
  ) dut (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(en_n),
    .i_HCOUNTER(h), .i_VCOUNTER(v), .i_VIDEODATA(d),
    .o_PIX_VALID(pix_valid), .o_PIX_X(pix_x), .o_PIX_Y(pix_y), .o_FRAME_DONE(frame_done),
    .o_FRAME_CNT(frame_cnt), .o_FRAME_SUM(frame_sum), .o_FRAME_ERR(frame_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic e, input logic [8:0] hh, input logic [8:0] vv, input logic [11:0] dd);
    en_n = e; h = hh; v = vv; d = dd;
    @(posedge clk);
    #1;
    if (frame_done) dones++;
  endtask
  task automatic frame(input logic [11:0] first, input logic [11:0] last, input bit skip, input bit noise);
    for (int y = 16; y <= 18; y++)
      for (int x = 2; x <= 9; x++) begin
        if (skip && x == 5 && y == 17) continue;
        cyc(1'b0, 9'(x), 9'(y), (x == 2 && y == 16) ? first : (x == 9 && y == 18) ? last : 12'h000);
        if (noise) cyc(1'b0, nh[(x + y) % 5], nv[(x + y) % 5], 12'hFFF);
      end
    cyc(1'b1, 9'd0, 9'd0, 12'h000);
  endtask
  initial begin
    cyc(1'b0, 9'd2, 9'd16, 12'hFFF);
    cyc(1'b0, 9'd9, 9'd18, 12'hFFF);
    cyc(1'b0, 9'd3, 9'd16, 12'hABC);
    chk("rst_valid", pix_valid, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_done", dones, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_sum", frame_sum, 0);
    chk("rst_err", frame_err, 0);
    rst_n = 1'b1;
    cyc(1'b1, 9'd0, 9'd0, 12'h000);
    for (int x = 4; x <= 9; x++) cyc(1'b0, 9'(x), 9'd18, 12'hFFF);
    cyc(1'b1, 9'd0, 9'd0, 12'h000);
    chk("partial_ignored_done", dones, 0);
    chk("partial_ignored_cnt", frame_cnt, 0);
    // full frame of black
    dones = 0;
    frame(12'h000, 12'h000, 1'b0, 1'b0);
    chk("f0_dones", dones, 1);
    chk("f0_sum", frame_sum, 32'h0);
    chk("f0_cnt", frame_cnt, 1);
    chk("f0_err", frame_err, 0);
    chk("f0_done_cleared", frame_done, 0);
    chk("f0_valid_cleared", pix_valid, 0);
    chk("f0_last_x", pix_x, 7);
    chk("f0_last_y", pix_y, 2);
    // single 1 at top-left rotated 23 times
    dones = 0;
    frame(12'h001, 12'h000, 1'b0, 1'b0);
    chk("f1_dones", dones, 1);
    chk("f1_sum", frame_sum, 32'h0080_0000);
    chk("f1_cnt", frame_cnt, 2);
    chk("f1_err", frame_err, 0);
    // enable held high all frame
    dones = 0;
    for (int y = 16; y <= 18; y++)
      for (int x = 2; x <= 9; x++) cyc(1'b1, 9'(x), 9'(y), 12'hFFF);
    chk("noen_dones", dones, 0);
    chk("noen_cnt", frame_cnt, 2);
    chk("noen_sum", frame_sum, 32'h0080_0000);
    chk("noen_valid", pix_valid, 0);
    // partial of 10 pixels then restart at top-left
    dones = 0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 9'(2 + i % 8), 9'(16 + i / 8), 12'hFFF);
    chk("part_valid", pix_valid, 1);
    chk("part_x", pix_x, 1);
    chk("part_y", pix_y, 1);
    cyc(1'b0, 9'd2, 9'd16, 12'h000);
    chk("abort_err", frame_err, 1);
    chk("abort_cnt", frame_cnt, 2);
    chk("abort_sum", frame_sum, 32'h0080_0000);
    chk("abort_x", pix_x, 0);
    frame(12'h000, 12'h003, 1'b0, 1'b0);
    chk("after_abort_dones", dones, 1);
    chk("after_abort_sum", frame_sum, 32'h3);
    chk("after_abort_cnt", frame_cnt, 3);
    chk("after_abort_err", frame_err, 0);
    // out-of-window pixels with white data interleaved
    dones = 0;
    frame(12'h000, 12'h000, 1'b0, 1'b1);
    chk("noise_dones", dones, 1);
    chk("noise_sum", frame_sum, 32'h0);
    chk("noise_cnt", frame_cnt, 4);
    chk("noise_err", frame_err, 0);
    // one pixel missing: done still pulses but count is short
    dones = 0;
    frame(12'h001, 12'h000, 1'b1, 1'b0);
    chk("short_dones", dones, 1);
    chk("short_sum", frame_sum, 32'h0040_0000);
    chk("short_cnt", frame_cnt, 5);
    chk("short_err", frame_err, 1);
    // asynchronous reset mid-frame
    cyc(1'b0, 9'd2, 9'd16, 12'h005);
    cyc(1'b0, 9'd3, 9'd16, 12'h005);
    rst_n = 1'b0;
    #1;
    chk("midrst_cnt", frame_cnt, 0);
    chk("midrst_sum", frame_sum, 0);
    chk("midrst_err", frame_err, 0);
    chk("midrst_valid", pix_valid, 0);
    cyc(1'b1, 9'd0, 9'd0, 12'h000);
    rst_n = 1'b1;
    dones = 0;
    for (int x = 4; x <= 9; x++) cyc(1'b0, 9'(x), 9'd16, 12'h005);
    for (int y = 17; y <= 18; y++)
      for (int x = 2; x <= 9; x++) cyc(1'b0, 9'(x), 9'(y), 12'h005);
    chk("midrst_tail_dones", dones, 0);
    frame(12'h000, 12'h000, 1'b0, 1'b0);
    chk("midrst_next_dones", dones, 1);
    chk("midrst_next_cnt", frame_cnt, 1);
    chk("midrst_next_sum", frame_sum, 0);
    chk("midrst_next_err", frame_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
